aligned_ram_playback_ctrl: RTL and testbench
============================================

ALIGNED_RAM_PLAYBACK_CTRL -- requirements
Module: aligned_ram_playback_ctrl

Interface
REQ-001 SHALL have parameter DOUT_ADDR_WIDTH, default 10, read-side (wide-word) address width.
REQ-002 SHALL have parameter N_DIN_TO_DOUT, default 4, narrow writes per wide word (power of 2).
REQ-003 SHALL have parameter READ_LATENCY, default 2, RAM read_addr-to-read_data cycles (>=1).
REQ-004 SHALL have ports, in order:
 clk  in  1  sole clock, rising edge.
 rst_n  in  1  asynchronous active-low reset.
 start  in  1  request playback (sampled in IDLE only).
 stop  in  1  abort playback.
 start_addr  in  DOUT_ADDR_WIDTH  first wide word.
 end_addr  in  DOUT_ADDR_WIDTH  last wide word, inclusive.
 loop  in  1  repeat start..end until stop (LOOP_EN builds only).
 host_write_enable  in  1  host narrow-write request.
 ram_write_enable  out  1  gated write enable to RAM.
 ram_read_addr  out  DOUT_ADDR_WIDTH  RAM read address.
 dout_valid  out  1  RAM read_data valid this cycle.
 busy  out  1  high in RUN or DRAIN.
 done  out  1  one-cycle pulse at playback end.
 write_reject  out  1  one-cycle pulse, host write dropped.
REQ-005 SHALL use one clock; reset asynchronous, active-low.

Function
REQ-006 SHALL implement states IDLE, RUN, DRAIN.
REQ-007 IDLE: start=1 SHALL latch start_addr, end_addr, loop; set ram_read_addr=start_addr; enter RUN next cycle.
REQ-008 RUN: each cycle SHALL issue one read; address advances +1 modulo 2**DOUT_ADDR_WIDTH (wrap past max allowed, so end<start is legal).
REQ-009 RUN, issued address == latched end: latched loop=1 SHALL reload start address next cycle; else enter DRAIN.
REQ-010 start_addr == end_addr SHALL play exactly one word (per pass).
REQ-011 stop=1 in RUN SHALL make that cycle's address the last issued and enter DRAIN; stop in IDLE/DRAIN ignored.
REQ-012 start while busy SHALL be ignored; start and stop together in IDLE: start accepted, stop ignored.
REQ-013 dout_valid SHALL equal the "read issued" flag delayed exactly READ_LATENCY cycles.
REQ-014 Latency: start sampled at edge k -> first address at k+1 -> first dout_valid at k+1+READ_LATENCY.
REQ-015 DRAIN SHALL last until every issued read has produced dout_valid; done pulses in the cycle after the last dout_valid, state returns to IDLE same edge.
REQ-016 ram_read_addr SHALL hold its last value outside RUN.
REQ-017 ram_write_enable SHALL equal host_write_enable when not busy, else 0.
REQ-018 write_reject SHALL pulse for each cycle host_write_enable=1 while busy.

Reset
REQ-019 rst_n low SHALL force IDLE, ram_read_addr=0, dout_valid=0, busy=0, done=0, write_reject=0, ram_write_enable=0, and clear the valid delay line and latched registers.
REQ-020 Reset mid-RUN/DRAIN SHALL discard in-flight valids; no done pulse.

Configuration
REQ-021 Macro ALIGNED_RAM_PLAYBACK_LOOP_EN SHALL compile in loop support per REQ-009.
REQ-022 Without ALIGNED_RAM_PLAYBACK_LOOP_EN, loop port SHALL exist but be ignored (latched loop constant 0); every playback is single-pass.

Structure
REQ-023 Shared package aligned_ram_pkg SHALL hold the state enum typedef (IDLE/RUN/DRAIN) and default parameter constants.
REQ-024 Valid delay line SHALL be a sub-module valid_delay_line (parameter DEPTH=READ_LATENCY, 1-bit shift register, async active-low clear).

Verification
REQ-025 start, start_addr=5, end_addr=8, READ_LATENCY=2 -> addresses 5,6,7,8 on consecutive cycles; dout_valid 4 cycles from start+3; done one cycle after last valid.
REQ-026 start_addr=1022, end_addr=1, DOUT_ADDR_WIDTH=10 -> addresses 1022,1023,0,1; 4 valids; done.
REQ-027 LOOP_EN built, loop=1, start=2, end=3, stop after 5 issues -> 2,3,2,3,2; exactly 5 valids; done.
REQ-028 host_write_enable=1 for 3 cycles during RUN, then 1 cycle in IDLE -> ram_write_enable 0 and write_reject 3 pulses, then ram_write_enable 1 with no reject.
REQ-029 rst_n low 2 cycles into RUN -> all outputs 0 asynchronously, no dout_valid or done afterward; following start plays normally.
REQ-030 start_addr=end_addr=7, start re-asserted during DRAIN -> one address 7, one valid, one done; second start ignored.

Source files
------------

// File: rtl/aligned_ram_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Package : aligned_ram_pkg                                                  |
// | Shared state encoding and default sizing for the aligned RAM playback block|
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
package aligned_ram_pkg;

    localparam int DEF_DOUT_ADDR_WIDTH = 10;
    localparam int DEF_N_DIN_TO_DOUT   = 4;
    localparam int DEF_READ_LATENCY    = 2;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        DRAIN = 2'd2
    } state_e;

endpackage
`default_nettype wire

// File: rtl/valid_delay_line.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module  : valid_delay_line                                                 |
// | 1-bit shift register delaying the read-issued flag by DEPTH cycles         |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
module valid_delay_line
    import aligned_ram_pkg::*;
#(
    parameter int DEPTH = DEF_READ_LATENCY
) (
    input  logic clk,
    input  logic rst_n,
    input  logic issue_i,
    output logic valid_o,
    output logic pending_o
);

    logic [DEPTH-1:0] shift_q;

    generate
        if (DEPTH == 1) begin : g_single
            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    shift_q <= '0;
                end else begin
                    shift_q <= issue_i;
                end
            end
            assign pending_o = 1'b0;
        end else begin : g_multi
            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    shift_q <= '0;
                end else begin
                    shift_q <= {shift_q[DEPTH-2:0], issue_i};
                end
            end
            // Reads still in flight behind the one emerging this cycle.
            assign pending_o = |shift_q[DEPTH-2:0];
        end
    endgenerate

    assign valid_o = shift_q[DEPTH-1];

endmodule
`default_nettype wire

// File: rtl/aligned_ram_playback_ctrl.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module  : aligned_ram_playback_ctrl                                        |
// | Plays a wide-word RAM region start..end (wrapping), tracks read latency,   |
// | and gates host writes while busy. Define ALIGNED_RAM_PLAYBACK_LOOP_EN to   |
// | enable looped playback via the loop input.                                 |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
module aligned_ram_playback_ctrl
    import aligned_ram_pkg::*;
#(
    parameter int DOUT_ADDR_WIDTH = DEF_DOUT_ADDR_WIDTH,
    parameter int N_DIN_TO_DOUT   = DEF_N_DIN_TO_DOUT,
    parameter int READ_LATENCY    = DEF_READ_LATENCY
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       start,
    input  logic                       stop,
    input  logic [DOUT_ADDR_WIDTH-1:0] start_addr,
    input  logic [DOUT_ADDR_WIDTH-1:0] end_addr,
    input  logic                       loop,
    input  logic                       host_write_enable,
    output logic                       ram_write_enable,
    output logic [DOUT_ADDR_WIDTH-1:0] ram_read_addr,
    output logic                       dout_valid,
    output logic                       busy,
    output logic                       done,
    output logic                       write_reject
);

    // Write-side packing ratio only matters to the RAM wrapper, not the sequencer.
    localparam int c_unused_din_ratio = N_DIN_TO_DOUT;

    state_e                       state_q;
    logic [DOUT_ADDR_WIDTH-1:0]   addr_q;
    logic [DOUT_ADDR_WIDTH-1:0]   start_q;
    logic [DOUT_ADDR_WIDTH-1:0]   end_q;
    logic                         loop_q;
    logic                         done_q;
    logic                         read_issue;
    logic                         drain_pending;

`ifndef ALIGNED_RAM_PLAYBACK_LOOP_EN
    logic unused_loop;
    assign unused_loop = loop;
`endif

    assign read_issue = (state_q == RUN);

    valid_delay_line #(
        .DEPTH (READ_LATENCY)
    ) u_valid_delay (
        .clk       (clk),
        .rst_n     (rst_n),
        .issue_i   (read_issue),
        .valid_o   (dout_valid),
        .pending_o (drain_pending)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            addr_q  <= '0;
            start_q <= '0;
            end_q   <= '0;
            loop_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            done_q <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (start) begin
                        start_q <= start_addr;
                        end_q   <= end_addr;
`ifdef ALIGNED_RAM_PLAYBACK_LOOP_EN
                        loop_q  <= loop;
`else
                        loop_q  <= 1'b0;
`endif
                        addr_q  <= start_addr;
                        state_q <= RUN;
                    end
                end
                RUN: begin
                    if (stop) begin
                        state_q <= DRAIN;
                    end else if (addr_q == end_q) begin
                        if (loop_q) begin
                            addr_q <= start_q;
                        end else begin
                            state_q <= DRAIN;
                        end
                    end else begin
                        addr_q <= addr_q + 1'b1;
                    end
                end
                DRAIN: begin
                    // Leave once the final valid is on the output this cycle.
                    if (!drain_pending) begin
                        state_q <= IDLE;
                        done_q  <= 1'b1;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign busy             = (state_q != IDLE);
    assign ram_read_addr    = addr_q;
    assign done             = done_q;
    assign ram_write_enable = rst_n & host_write_enable & ~busy;
    assign write_reject     = host_write_enable & busy;

endmodule
`default_nettype wire

// File: tb/tb_aligned_ram_playback_ctrl.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module  : tb_aligned_ram_playback_ctrl                                     |
// | Self-checking bench: per-cycle model comparison plus literal scenarios     |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
module tb_aligned_ram_playback_ctrl;

    localparam int AW = 10;
    localparam int L  = 2;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          start, stop, loop, host_write_enable;
    logic [AW-1:0] start_addr, end_addr;
    logic          ram_write_enable, dout_valid, busy, done, write_reject;
    logic [AW-1:0] ram_read_addr;

    always #5 clk = ~clk;

    aligned_ram_playback_ctrl #(
        .DOUT_ADDR_WIDTH (AW),
        .N_DIN_TO_DOUT   (4),
        .READ_LATENCY    (L)
    ) dut (
        .clk               (clk),
        .rst_n             (rst_n),
        .start             (start),
        .stop              (stop),
        .start_addr        (start_addr),
        .end_addr          (end_addr),
        .loop              (loop),
        .host_write_enable (host_write_enable),
        .ram_write_enable  (ram_write_enable),
        .ram_read_addr     (ram_read_addr),
        .dout_valid        (dout_valid),
        .busy              (busy),
        .done              (done),
        .write_reject      (write_reject)
    );

    int checks   = 0;
    int failures = 0;

    task automatic chk(input string nm, input int act, input int exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("FAIL %s actual=%0d expected=%0d at t=%0t", nm, act, exp, $time);
        end
    endtask

    // Behavioural model: playback as a list of issue cycles; a valid is due
    // exactly L cycles after each issue, done one cycle after the final one.
    bit            m_run = 0, m_drain = 0, m_valid = 0, m_done = 0, m_loop = 0, m_nd = 0;
    logic [AW-1:0] m_addr = '0, m_s = '0, m_e = '0;
    int            cyc = 0;
    int            iss_q[$];

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_run = 0; m_drain = 0; m_valid = 0; m_done = 0; m_loop = 0;
            m_addr = '0; m_s = '0; m_e = '0;
            iss_q.delete();
        end else begin
            m_nd = m_drain && m_valid && (iss_q.size() == 0);
            if (m_run) begin
                iss_q.push_back(cyc);
                if (stop) begin
                    m_run = 0; m_drain = 1;
                end else if (m_addr == m_e) begin
                    if (m_loop) m_addr = m_s;
                    else begin m_run = 0; m_drain = 1; end
                end else begin
                    m_addr = m_addr + 1'b1;
                end
            end else if (!m_drain && start) begin
                m_s = start_addr; m_e = end_addr; m_addr = start_addr; m_run = 1;
`ifdef ALIGNED_RAM_PLAYBACK_LOOP_EN
                m_loop = loop;
`else
                m_loop = 0;
`endif
            end
            if (m_nd) m_drain = 0;
            cyc++;
            m_valid = 0;
            if (iss_q.size() > 0 && iss_q[0] == cyc - L) begin
                m_valid = 1;
                void'(iss_q.pop_front());
            end
            m_done = m_nd;
        end
    end

    // Per-cycle comparison and scenario logging.
    int act_addrs[$];
    int n_valid, n_done, n_rej, n_we, first_valid, done_cyc;

    always @(negedge clk) begin
        chk("ram_read_addr", int'(ram_read_addr), int'(m_addr));
        chk("busy", int'(busy), int'(m_run || m_drain));
        chk("dout_valid", int'(dout_valid), int'(m_valid));
        chk("done", int'(done), int'(m_done));
        chk("ram_write_enable", int'(ram_write_enable), int'(rst_n && host_write_enable && !(m_run || m_drain)));
        chk("write_reject", int'(write_reject), int'(host_write_enable && (m_run || m_drain)));
        if (m_run) act_addrs.push_back(int'(ram_read_addr));
        if (dout_valid) begin
            n_valid++;
            if (first_valid < 0) first_valid = cyc;
        end
        if (done) begin
            n_done++;
            if (done_cyc < 0) done_cyc = cyc;
        end
        if (write_reject) n_rej++;
        if (ram_write_enable) n_we++;
    end

    task automatic clear_log();
        act_addrs.delete();
        n_valid = 0; n_done = 0; n_rej = 0; n_we = 0;
        first_valid = -1; done_cyc = -1;
    endtask

    task automatic chk_seq(input string nm, input int n, input int e0, input int e1,
                           input int e2, input int e3, input int e4);
        int e[5];
        int bad;
        e = '{e0, e1, e2, e3, e4};
        bad = -1;
        checks++;
        if (act_addrs.size() != n) bad = 99;
        else for (int i = 0; i < n; i++) if (bad < 0 && act_addrs[i] != e[i]) bad = i;
        if (bad >= 0) begin
            failures++;
            if (bad == 99)
                $display("FAIL %s address count actual=%0d expected=%0d", nm, act_addrs.size(), n);
            else
                $display("FAIL %s address[%0d] actual=%0d expected=%0d", nm, bad, act_addrs[bad], e[bad]);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    int base;

    task automatic do_start(input int s, input int e, input bit lp);
        start = 1'b1; start_addr = AW'(s); end_addr = AW'(e); loop = lp;
        tick();
        start = 1'b0;
        base = cyc;
    endtask

    task automatic wait_idle();
        bit ok;
        ok = 0;
        for (int i = 0; i < 300; i++) begin
            tick();
            if (!m_run && !m_drain && !m_done) begin
                ok = 1;
                break;
            end
        end
        if (!ok) chk("idle_timeout", 1, 0);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog expired checks=%0d failures=%0d", checks, failures);
        $fatal(1);
    end

    initial begin
        rst_n = 1'b0; start = 1'b0; stop = 1'b0; loop = 1'b0; host_write_enable = 1'b0;
        start_addr = '0; end_addr = '0;
        clear_log();
        tick(); tick();
        chk("reset_addr", int'(ram_read_addr), 0);
        chk("reset_busy", int'(busy), 0);
        chk("reset_valid", int'(dout_valid), 0);
        chk("reset_done", int'(done), 0);
        rst_n = 1'b1;
        tick();

        // Basic playback 5..8 with latency check
        clear_log();
        do_start(5, 8, 0);
        wait_idle();
        chk_seq("play_5_8", 4, 5, 6, 7, 8, 0);
        chk("play_5_8_valids", n_valid, 4);
        chk("play_5_8_dones", n_done, 1);
        chk("play_5_8_first_valid_lat", first_valid - base, 2);
        chk("play_5_8_done_lat", done_cyc - base, 6);

        // Address wrap 1022..1
        clear_log();
        do_start(1022, 1, 0);
        wait_idle();
        chk_seq("wrap", 4, 1022, 1023, 0, 1, 0);
        chk("wrap_valids", n_valid, 4);
        chk("wrap_dones", n_done, 1);

        // Host writes during RUN then in IDLE
        clear_log();
        do_start(10, 20, 0);
        host_write_enable = 1'b1;
        tick(); tick(); tick();
        host_write_enable = 1'b0;
        wait_idle();
        host_write_enable = 1'b1;
        tick();
        host_write_enable = 1'b0;
        tick();
        chk("write_rejects", n_rej, 3);
        chk("write_enables", n_we, 1);

        // Asynchronous reset during RUN
        clear_log();
        do_start(100, 110, 0);
        tick();
        host_write_enable = 1'b1;
        #2 rst_n = 1'b0;
        #1;
        chk("arst_addr", int'(ram_read_addr), 0);
        chk("arst_busy", int'(busy), 0);
        chk("arst_valid", int'(dout_valid), 0);
        chk("arst_done", int'(done), 0);
        chk("arst_reject", int'(write_reject), 0);
        chk("arst_we", int'(ram_write_enable), 0);
        clear_log();
        tick();
        host_write_enable = 1'b0;
        rst_n = 1'b1;
        repeat (6) tick();
        chk("post_arst_valids", n_valid, 0);
        chk("post_arst_dones", n_done, 0);
        clear_log();
        do_start(3, 4, 0);
        wait_idle();
        chk_seq("post_arst_play", 2, 3, 4, 0, 0, 0);
        chk("post_arst_play_valids", n_valid, 2);
        chk("post_arst_play_dones", n_done, 1);

        // Single word with start re-asserted during DRAIN
        clear_log();
        do_start(7, 7, 0);
        tick();
        start = 1'b1; start_addr = AW'(9); end_addr = AW'(12);
        tick();
        start = 1'b0;
        wait_idle();
        repeat (4) tick();
        chk_seq("single_word", 1, 7, 0, 0, 0, 0);
        chk("single_word_valids", n_valid, 1);
        chk("single_word_dones", n_done, 1);

        // Stop on the third issued address
        clear_log();
        do_start(20, 30, 0);
        tick(); tick();
        stop = 1'b1;
        tick();
        stop = 1'b0;
        wait_idle();
        chk_seq("stop_run", 3, 20, 21, 22, 0, 0);
        chk("stop_run_valids", n_valid, 3);
        chk("stop_run_dones", n_done, 1);

        // Start and stop together in IDLE: start wins
        clear_log();
        stop = 1'b1;
        do_start(40, 41, 0);
        stop = 1'b0;
        wait_idle();
        chk_seq("start_stop_idle", 2, 40, 41, 0, 0, 0);
        chk("start_stop_idle_valids", n_valid, 2);

        // Loop request
        clear_log();
        do_start(2, 3, 1);
`ifdef ALIGNED_RAM_PLAYBACK_LOOP_EN
        repeat (4) tick();
        stop = 1'b1;
        tick();
        stop = 1'b0;
        wait_idle();
        chk_seq("loop_stop", 5, 2, 3, 2, 3, 2);
        chk("loop_stop_valids", n_valid, 5);
        chk("loop_stop_dones", n_done, 1);
`else
        wait_idle();
        chk_seq("loop_ignored", 2, 2, 3, 0, 0, 0);
        chk("loop_ignored_valids", n_valid, 2);
        chk("loop_ignored_dones", n_done, 1);
`endif

        tick();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire
